// File: rtl/mmio_pkg.sv
// ----------------------------------------------------------------------------
// mmio_pkg
//   Shared constants for the MEM-stage memory-mapped I/O responder:
//   - IO_BASE_DEFAULT : default base of the 16-byte I/O window
//   - OFS_*           : register select values taken from Address[3:2]
//   - PORT_IN_W       : width of the external PortIn pins
// ----------------------------------------------------------------------------
package mmio_pkg;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h1001_0100;

    localparam logic [1:0] OFS_PORT_OUT = 2'd0;
    localparam logic [1:0] OFS_PORT_IN  = 2'd1;
    localparam logic [1:0] OFS_IN_EDGE  = 2'd2;
    localparam logic [1:0] OFS_TIMER    = 2'd3;

    localparam int PORT_IN_W = 8;

endpackage

// File: rtl/input_sync_edge.sv
// ----------------------------------------------------------------------------
// input_sync_edge
//   Three-flop synchronizer for asynchronous input pins plus a rising-edge
//   pulse derived from the last two stages.
//   Ports:
//     clk      : system clock, rising edge
//     reset    : synchronous, active-high; clears all stages
//     din      : asynchronous input pins
//     sync_out : second synchronizer stage (metastability-settled value)
//     rise     : one-cycle pulse per bit when sync_out goes 0 -> 1
// ----------------------------------------------------------------------------
module input_sync_edge #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] sync_out,
    output logic [W-1:0] rise
);

    logic [W-1:0] s1_q, s1_d;
    logic [W-1:0] s2_q, s2_d;
    logic [W-1:0] s3_q, s3_d;

    always_comb begin
        s1_d = din;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    // s3 is only a delayed copy of s2, used to detect the 0 -> 1 transition.
    assign sync_out = s2_q;
    assign rise     = s2_q & ~s3_q;

endmodule

// File: rtl/mmio_port_controller.sv
// ----------------------------------------------------------------------------
// mmio_port_controller
//   MEM-stage memory-mapped I/O responder. Loads/stores whose address lies
//   in the 16-byte window at IO_BASE are serviced here; Hit tells the top
//   level to take ReadData instead of data-memory read data.
//
//   Bus behaviour: there is no handshake. MemRead/MemWrite act as
//   always-accepted requests; the block is always ready, never stalls, and
//   a read answers combinationally in the same cycle.
//
//   Register map (Address[3:2]):
//     0x0 PORT_OUT  R/W  drives PortOut
//     0x4 PORT_IN   RO   zero-extended synchronized PortIn
//     0x8 IN_EDGE   W1C  sticky rising-edge flags in [7:0]
//     0xC TIMER     R/W  free-running counter; a write loads it
//
//   Ports:
//     clk, reset         : clock and synchronous active-high reset
//     MemWrite, MemRead  : MEM-stage store / load strobes
//     Address, WriteData : MEM-stage byte address and store data
//     PortIn             : asynchronous external input pins
//     ReadData, Hit      : combinational load data and window-hit flag
//     PortOut            : output port register
//     EdgePending        : OR of all edge flags
// ----------------------------------------------------------------------------
module mmio_port_controller
    import mmio_pkg::*;
#(
    parameter int               NBits   = 32,
    parameter logic [NBits-1:0] IO_BASE = IO_BASE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 MemWrite,
    input  logic                 MemRead,
    input  logic [NBits-1:0]     Address,
    input  logic [NBits-1:0]     WriteData,
    input  logic [PORT_IN_W-1:0] PortIn,
    output logic [NBits-1:0]     ReadData,
    output logic                 Hit,
    output logic [NBits-1:0]     PortOut,
    output logic                 EdgePending
);

    logic                 in_window;
    logic [1:0]           reg_sel;
    logic                 wr_en;
    logic [PORT_IN_W-1:0] port_in_sync;
    logic [PORT_IN_W-1:0] port_in_rise;

    logic [NBits-1:0]     port_out_q,   port_out_d;
    logic [NBits-1:0]     timer_q,      timer_d;
    logic [PORT_IN_W-1:0] edge_flags_q, edge_flags_d;
    logic [PORT_IN_W-1:0] edge_clear;

    // Word access only: byte-lane bits are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^Address[1:0];

    input_sync_edge #(
        .W (PORT_IN_W)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .din      (PortIn),
        .sync_out (port_in_sync),
        .rise     (port_in_rise)
    );

    // Decode
    assign in_window = (Address[NBits-1:4] == IO_BASE[NBits-1:4]);
    assign reg_sel   = Address[3:2];
    assign Hit       = in_window & (MemRead | MemWrite);
    assign wr_en     = in_window & MemWrite;

    // Next-state logic for the architectural registers
    always_comb begin
        port_out_d = port_out_q;
        timer_d    = timer_q + {{(NBits-1){1'b0}}, 1'b1};
        edge_clear = '0;

        if (wr_en) begin
            unique case (reg_sel)
                OFS_PORT_OUT: port_out_d = WriteData;
                OFS_PORT_IN:  ;  // read-only, writes dropped
                OFS_IN_EDGE:  edge_clear = WriteData[PORT_IN_W-1:0];
                OFS_TIMER:    timer_d    = WriteData;
                default:      ;
            endcase
        end

        // Set is applied after clear so a coincident new edge is never lost.
        edge_flags_d = (edge_flags_q & ~edge_clear) | port_in_rise;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            port_out_q   <= '0;
            timer_q      <= '0;
            edge_flags_q <= '0;
        end else begin
            port_out_q   <= port_out_d;
            timer_q      <= timer_d;
            edge_flags_q <= edge_flags_d;
        end
    end

    // Read mux: reflects current (pre-write) register contents.
    always_comb begin
        ReadData = '0;
        if (in_window && MemRead) begin
            unique case (reg_sel)
                OFS_PORT_OUT: ReadData = port_out_q;
                OFS_PORT_IN:  ReadData = {{(NBits-PORT_IN_W){1'b0}}, port_in_sync};
                OFS_IN_EDGE:  ReadData = {{(NBits-PORT_IN_W){1'b0}}, edge_flags_q};
                OFS_TIMER:    ReadData = timer_q;
                default:      ReadData = '0;
            endcase
        end
    end

    assign PortOut     = port_out_q;
    assign EdgePending = |edge_flags_q;

endmodule

// File: tb/tb_mmio_port_controller.sv
// ----------------------------------------------------------------------------
// tb_mmio_port_controller
//   Directed bench. The driver issues one bus operation per cycle and pushes
//   the hand-computed expected outputs for that cycle, tagged with the cycle
//   number, into exp_q. The monitor samples the DUT on the falling edge and
//   pops/compares every entry tagged with the current cycle.
// ----------------------------------------------------------------------------
module tb_mmio_port_controller;

    localparam int          W       = 32;
    localparam logic [31:0] IO_BASE = 32'h1001_0100;

    localparam int F_RDATA = 0;
    localparam int F_HIT   = 1;
    localparam int F_PORT  = 2;
    localparam int F_EP    = 3;

    typedef struct {
        int          cyc;
        int          field;
        logic [W-1:0] value;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          mem_write;
    logic          mem_read;
    logic [W-1:0]  address;
    logic [W-1:0]  write_data;
    logic [7:0]    port_in;
    logic [W-1:0]  read_data;
    logic          hit;
    logic [W-1:0]  port_out;
    logic          edge_pending;

    exp_t exp_q[$];
    int   cyc;
    int   checks;
    int   errors;

    mmio_port_controller #(
        .NBits   (W),
        .IO_BASE (IO_BASE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .MemWrite    (mem_write),
        .MemRead     (mem_read),
        .Address     (address),
        .WriteData   (write_data),
        .PortIn      (port_in),
        .ReadData    (read_data),
        .Hit         (hit),
        .PortOut     (port_out),
        .EdgePending (edge_pending)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete (got running, want finished)");
        $fatal(1, "timeout");
    end

    // ---------------- driver tasks ----------------
    task automatic expect_out(input int field, input logic [W-1:0] value);
        exp_t e;
        e.cyc   = cyc;
        e.field = field;
        e.value = value;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [W-1:0] a,
                         input logic [W-1:0] wd);
        mem_read   = r;
        mem_write  = w;
        address    = a;
        write_data = wd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic rd(input logic [W-1:0] ofs, input logic [W-1:0] value);
        drive(1'b1, 1'b0, IO_BASE + ofs, 32'h0);
        expect_out(F_RDATA, value);
        expect_out(F_HIT, 32'd1);
        tick();
    endtask

    task automatic wr(input logic [W-1:0] ofs, input logic [W-1:0] data);
        drive(1'b0, 1'b1, IO_BASE + ofs, data);
        expect_out(F_HIT, 32'd1);
        expect_out(F_RDATA, 32'd0);
        tick();
    endtask

    // ---------------- scoreboard / monitor ----------------
    function automatic string fname(input int f);
        case (f)
            F_RDATA: return "ReadData";
            F_HIT:   return "Hit";
            F_PORT:  return "PortOut";
            default: return "EdgePending";
        endcase
    endfunction

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            exp_t e;
            logic [W-1:0] act;
            e = exp_q.pop_front();
            case (e.field)
                F_RDATA: act = read_data;
                F_HIT:   act = {31'd0, hit};
                F_PORT:  act = port_out;
                default: act = {31'd0, edge_pending};
            endcase
            checks++;
            if (act !== e.value) begin
                errors++;
                $display("FAIL %s cycle %0d: got %h want %h", fname(e.field), cyc, act, e.value);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        port_in = 8'hFF;
        drive(1'b0, 1'b0, 32'h0, 32'h0);

        // Reset, PortIn held high throughout.
        tick();
        repeat (2) begin
            expect_out(F_PORT, 32'd0);
            expect_out(F_EP, 32'd0);
            tick();
        end
        reset = 1'b0;

        // Timer counts 0,1,2; edge flag appears after the third edge.
        expect_out(F_PORT, 32'd0);
        expect_out(F_EP, 32'd0);
        rd(32'hC, 32'd0);
        expect_out(F_EP, 32'd0);
        rd(32'hC, 32'd1);
        expect_out(F_EP, 32'd0);
        rd(32'hC, 32'd2);
        expect_out(F_EP, 32'd1);
        rd(32'h8, 32'h0000_00FF);
        wr(32'h8, 32'h0000_00FF);
        expect_out(F_EP, 32'd0);
        rd(32'h4, 32'h0000_00FF);
        rd(32'h8, 32'h0);

        // PORT_OUT store, then an out-of-window store.
        wr(32'h0, 32'hDEAD_BEEF);
        expect_out(F_PORT, 32'hDEAD_BEEF);
        drive(1'b0, 1'b1, IO_BASE + 32'h10, 32'h1234_5678);
        expect_out(F_HIT, 32'd0);
        tick();
        expect_out(F_PORT, 32'hDEAD_BEEF);
        rd(32'h0, 32'hDEAD_BEEF);
        // In-window address with no strobe: no hit, no data.
        drive(1'b0, 1'b0, IO_BASE, 32'h0);
        expect_out(F_HIT, 32'd0);
        expect_out(F_RDATA, 32'd0);
        tick();

        // PortIn 00 -> 05.
        port_in = 8'h00;
        repeat (4) idle();
        port_in = 8'h05;
        idle();
        rd(32'h4, 32'h0);
        expect_out(F_EP, 32'd0);
        rd(32'h4, 32'h5);
        expect_out(F_EP, 32'd1);
        rd(32'h8, 32'h5);
        wr(32'h8, 32'h1);
        expect_out(F_EP, 32'd1);
        rd(32'h8, 32'h4);

        // Writes to PORT_IN are ignored.
        wr(32'h4, 32'hFFFF_FFFF);
        rd(32'h4, 32'h5);
        expect_out(F_PORT, 32'hDEAD_BEEF);
        rd(32'h0, 32'hDEAD_BEEF);

        // New rising edge on bit 2 coinciding with its W1C: set wins.
        port_in = 8'h01;
        repeat (4) idle();
        rd(32'h8, 32'h4);
        port_in = 8'h05;
        idle();
        idle();
        wr(32'h8, 32'h4);
        rd(32'h8, 32'h4);
        wr(32'h8, 32'h4);
        expect_out(F_EP, 32'd0);
        rd(32'h8, 32'h0);

        // Timer load and wrap; byte-offset bits ignored on the address.
        wr(32'hC, 32'hFFFF_FFFE);
        rd(32'hC, 32'hFFFF_FFFE);
        rd(32'hF, 32'hFFFF_FFFF);
        rd(32'hC, 32'h0);

        // Read and write together on PORT_OUT: read sees pre-write value.
        wr(32'h0, 32'h1);
        drive(1'b1, 1'b1, IO_BASE, 32'h2);
        expect_out(F_RDATA, 32'h1);
        expect_out(F_HIT, 32'd1);
        tick();
        expect_out(F_PORT, 32'h2);
        rd(32'h3, 32'h2);
        drive(1'b1, 1'b0, 32'h1001_0000, 32'h0);
        expect_out(F_RDATA, 32'h0);
        expect_out(F_HIT, 32'd0);
        tick();

        // Reset overrides a coincident write.
        reset = 1'b1;
        drive(1'b0, 1'b1, IO_BASE, 32'hAAAA_AAAA);
        tick();
        reset = 1'b0;
        expect_out(F_PORT, 32'h0);
        expect_out(F_EP, 32'd0);
        rd(32'hC, 32'h0);
        rd(32'h8, 32'h0);

        idle();
        idle();

        // ---------------- final report ----------------
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
